// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between an atomic fixed-length message printer and a byte-wide
// RX echo path, interleaving them only at message boundaries.
module uart_tx_arbiter #(
    parameter int MSG_BYTES  = 21,
    parameter int ECHO_DEPTH = 4
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [MSG_BYTES*8-1:0]        msg_data,
    input  logic                          msg_req,
    output logic                          msg_busy,
    output logic                          msg_dropped,
    input  logic [7:0]                    echo_data,
    input  logic                          echo_valid,
    output logic                          echo_overflow,
    output logic [$clog2(ECHO_DEPTH):0]   echo_level,
    output logic [7:0]                    tx_data,
    output logic                          tx_data_valid,
    input  logic                          tx_data_ready
);

    localparam int              AW        = $clog2(ECHO_DEPTH);
    localparam int              MW        = MSG_BYTES * 8;
    localparam logic [AW:0]     FULL_LVL  = (AW + 1)'(ECHO_DEPTH);
    localparam logic [7:0]      LAST_IDX  = 8'(MSG_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MSG,
        S_ECHO,
        S_GAP
    } state_t;

    typedef enum logic {
        GRANT_MSG,
        GRANT_ECHO
    } grant_t;

    state_t        state, state_nxt;
    grant_t        last_grant, last_grant_nxt;
    logic          gap_to_msg, gap_to_msg_nxt;
    logic [7:0]    msg_idx, msg_idx_nxt;
    logic [MW-1:0] shadow;

    logic [7:0]    fifo_mem [ECHO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;

    logic          xfer, msg_xfer, msg_done;

    assign xfer       = tx_data_valid && tx_data_ready;
    assign msg_xfer   = (state == S_MSG) && xfer;
    assign msg_done   = msg_xfer && (msg_idx == LAST_IDX);

    assign fifo_full  = (echo_level == FULL_LVL);
    assign fifo_empty = (echo_level == '0);
    assign fifo_pop   = (state == S_ECHO) && xfer;
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign fifo_push  = echo_valid && (!fifo_full || fifo_pop);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        gap_to_msg_nxt = gap_to_msg;
        msg_idx_nxt    = msg_idx;
        case (state)
            S_IDLE: begin
                if (msg_busy && (fifo_empty || last_grant == GRANT_ECHO)) begin
                    state_nxt   = S_MSG;
                    msg_idx_nxt = '0;
                end else if (!fifo_empty) begin
                    state_nxt = S_ECHO;
                end
            end
            S_MSG: begin
                if (xfer) begin
                    state_nxt = S_GAP;
                    if (msg_idx == LAST_IDX) begin
                        gap_to_msg_nxt = 1'b0;
                        last_grant_nxt = GRANT_MSG;
                    end else begin
                        gap_to_msg_nxt = 1'b1;
                        msg_idx_nxt    = msg_idx + 8'd1;
                    end
                end
            end
            S_ECHO: begin
                if (xfer) begin
                    state_nxt      = S_GAP;
                    gap_to_msg_nxt = 1'b0;
                    last_grant_nxt = GRANT_ECHO;
                end
            end
            S_GAP:   state_nxt = gap_to_msg ? S_MSG : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= S_IDLE;
            last_grant <= GRANT_MSG;
            gap_to_msg <= 1'b0;
            msg_idx    <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            gap_to_msg <= gap_to_msg_nxt;
            msg_idx    <= msg_idx_nxt;
        end
    end

    // The shadow shifts left per transferred byte, so the next byte is always on top.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            msg_busy    <= 1'b0;
            msg_dropped <= 1'b0;
            shadow      <= '0;
        end else begin
            msg_dropped <= msg_req && msg_busy;
            if (msg_req && !msg_busy) begin
                msg_busy <= 1'b1;
                shadow   <= msg_data;
            end else begin
                if (msg_done) begin
                    msg_busy <= 1'b0;
                end
                if (msg_xfer) begin
                    shadow <= shadow << 8;
                end
            end
        end
    end

    // NOTE: storage array has no reset; the pointers and level alone define its contents.
    always_ff @(posedge sys_clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= echo_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            echo_level    <= '0;
            echo_overflow <= 1'b0;
        end else begin
            echo_overflow <= echo_valid && !fifo_push;
            if (fifo_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   echo_level <= echo_level + 1'b1;
                2'b01:   echo_level <= echo_level - 1'b1;
                default: echo_level <= echo_level;
            endcase
        end
    end

    // tx_data is loaded only on entry to MSG/ECHO, which holds it stable until the transfer.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
        end else begin
            tx_data_valid <= (state_nxt == S_MSG) || (state_nxt == S_ECHO);
            if (state != S_MSG && state_nxt == S_MSG) begin
                tx_data <= shadow[MW-1 -: 8];
            end else if (state != S_ECHO && state_nxt == S_ECHO) begin
                tx_data <= fifo_mem[rd_ptr];
            end
        end
    end

endmodule
